// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with one shared free-running period
// counter. Duty levels are accepted into a pending buffer through a
// valid/ready handshake. They move to the active set only at the period
// wrap, so every period is glitch-free and all channels switch together.
// Optional build macro: PWM_PHASE_STAGGER_EN. When it is defined, channel i
// compares (cnt + i*(2^WIDTH/CHANNELS)) mod 2^WIDTH instead of cnt.
module pwm_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] level_in,
    input  logic                      level_valid,
    output logic                      level_ready,
    output logic [CHANNELS-1:0]       out,
    output logic                      period_start
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
`ifdef PWM_PHASE_STAGGER_EN
    localparam longint unsigned PHASE_STEP = (64'd1 << WIDTH) / 64'(CHANNELS);
`endif

    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] pending [CHANNELS];
    logic [WIDTH-1:0] active  [CHANNELS];
    logic [WIDTH-1:0] phase   [CHANNELS];
    logic             pending_full;
    logic             transfer;
    logic             accept;

    // The reset term keeps ready low while reset is asserted, even though
    // pending_full is only cleared at the clock edge.
    assign level_ready = ~pending_full & ~reset;
    assign transfer    = enable & (cnt_p0 == CNT_MAX) & pending_full;
    assign accept      = level_valid & ~pending_full;

    // Shared period counter; it freezes while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if (enable) begin
            cnt_p0 <= cnt_p0 + WIDTH'(1);
        end
    end

    // Pending buffer fill and atomic transfer to the active set at the wrap.
    // No accept can happen while the buffer is full, so accept and transfer
    // never fire in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_full <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else if (transfer) begin
            pending_full <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= pending[i];
            end
        end else if (accept) begin
            pending_full <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= level_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Per-channel compare phase: either the raw count or a fixed rotation of it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            phase[i] = cnt_p0 + WIDTH'(PHASE_STEP * 64'(i));
`else
            phase[i] = cnt_p0;
`endif
        end
    end

    // ---- stage p0 -> p1: registered comparators and period marker ----
    // Registered comparators; period_start marks the output cycle built from cnt == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= enable & (cnt_p0 == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                out[i] <= enable & (phase[i] < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank (WIDTH=8, CHANNELS=3).
// A cycle model computes each expected {period_start, out} when inputs are
// driven. The value is queued and then compared after the next clock edge.
// Per-period duty counts, ready timing and rise positions are also checked
// against fixed values.
module tb_pwm_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] level_in;
    logic        level_valid;
    logic        level_ready;
    logic [2:0]  out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_bank #(.WIDTH(8), .CHANNELS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .level_in     (level_in),
        .level_valid  (level_valid),
        .level_ready  (level_ready),
        .out          (out),
        .period_start (period_start)
    );

`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFF  [3] = '{0, 85, 170};
    localparam int RISE [3] = '{0, 171, 86};
`else
    localparam int OFF  [3] = '{0, 0, 0};
    localparam int RISE [3] = '{0, 0, 0};
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q [$];
    logic [7:0] m_cnt = 8'd0;
    logic [7:0] m_act  [3] = '{8'd0, 8'd0, 8'd0};
    logic [7:0] m_pend [3] = '{8'd0, 8'd0, 8'd0};
    logic       m_pf = 1'b0;

    int         hi [3];
    int         rise_at [3];
    int         ps_n;
    logic [2:0] prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [7:0] tb_phase(input logic [7:0] c, input int ch);
        return c + 8'(OFF[ch]);
    endfunction

    task automatic clr_stats();
        hi       = '{0, 0, 0};
        rise_at  = '{-1, -1, -1};
        ps_n     = 0;
        prev_out = out;
    endtask

    // One clock: queue expected output, advance model, compare after the edge.
    task automatic step();
        logic [3:0] e;
        logic [7:0] c_pre;
        e = '0;
        c_pre = m_cnt;
        if (!reset) begin
            for (int i = 0; i < 3; i++) e[i] = enable && (tb_phase(m_cnt, i) < m_act[i]);
            e[3] = enable && (m_cnt == 8'd0);
        end
        exp_q.push_back(e);
        if (reset) begin
            m_cnt = 8'd0;
            m_pf  = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_act[i]  = 8'd0;
                m_pend[i] = 8'd0;
            end
        end else begin
            if (enable && m_cnt == 8'hFF && m_pf) begin
                for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
                m_pf = 1'b0;
            end else if (level_valid && !m_pf) begin
                for (int i = 0; i < 3; i++) m_pend[i] = level_in[i*8 +: 8];
                m_pf = 1'b1;
            end
            if (enable) m_cnt = m_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else check("out_ps", {period_start, out}, exp_q.pop_front());
        check("ready", level_ready, (!m_pf && !reset));
        for (int i = 0; i < 3; i++) begin
            if (out[i] === 1'b1) hi[i]++;
            if (out[i] === 1'b1 && prev_out[i] === 1'b0 && rise_at[i] < 0) rise_at[i] = c_pre;
        end
        prev_out = out;
        if (period_start === 1'b1) ps_n++;
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        for (int k = 0; k < 600 && m_cnt != v; k++) step();
        if (m_cnt != v) check("wait_cnt", m_cnt, v);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bit acc;
        acc = 1'b0;
        level_in    = {c, b, a};
        level_valid = 1'b1;
        for (int k = 0; k < 600 && !acc; k++) begin
            acc = !m_pf;
            step();
        end
        level_valid = 1'b0;
        if (!acc) check("load_timeout", 0, 1);
    endtask

    task automatic measure_period(input int e0, input int e1, input int e2);
        if (m_cnt != 8'd0 || !enable) check("meas_align", m_cnt, 0);
        clr_stats();
        repeat (256) step();
        check("hi_ch0", hi[0], e0);
        check("hi_ch1", hi[1], e1);
        check("hi_ch2", hi[2], e2);
        check("ps_per_period", ps_n, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        level_valid = 1'b0;
        level_in    = '0;

        // Reset defaults
        repeat (3) begin
            step();
            check("rst_out", {period_start, out}, 0);
            check("rst_ready", level_ready, 0);
        end
        reset = 1'b0;
        #1;
        check("rdy_release", level_ready, 1);

        // Basic duty over two full periods
        load(8'd64, 8'd128, 8'd255);
        wait_cnt(8'd0);
        measure_period(64, 128, 255);
        measure_period(64, 128, 255);

        // Boundary update: new set offered at cnt = 100
        load(8'd128, 8'd128, 8'd128);
        wait_cnt(8'd0);
        clr_stats();
        repeat (100) step();
        level_in    = {8'd32, 8'd32, 8'd32};
        level_valid = 1'b1;
        step();
        level_valid = 1'b0;
        check("bnd_rdy_drop", level_ready, 0);
        wait_cnt(8'd255);
        check("bnd_rdy_hold", level_ready, 0);
        step();
        check("bnd_rdy_rise", level_ready, 1);
        check("bnd_old_ch0", hi[0], 128);
        check("bnd_old_ch1", hi[1], 128);
        check("bnd_old_ch2", hi[2], 128);
        measure_period(32, 32, 32);

        // Back-pressure: A accepted at once, B held across the wrap
        level_in    = {8'd30, 8'd20, 8'd10};
        level_valid = 1'b1;
        step();
        check("bp_a_acc", level_ready, 0);
        level_in = {8'd60, 8'd50, 8'd40};
        repeat (255) step();
        check("bp_wrap_cnt", m_cnt, 0);
        check("bp_rdy_rise", level_ready, 1);
        clr_stats();
        step();
        level_valid = 1'b0;
        check("bp_b_acc", level_ready, 0);
        repeat (255) step();
        check("bp_a_ch0", hi[0], 10);
        check("bp_a_ch1", hi[1], 20);
        check("bp_a_ch2", hi[2], 30);
        measure_period(40, 50, 60);

        // Enable gating with level 0 channels
        load(8'd0, 8'd10, 8'd0);
        wait_cnt(8'd0);
        clr_stats();
        repeat (5) step();
        enable = 1'b0;
        repeat (20) begin
            step();
            check("pause_out", {period_start, out}, 0);
        end
        enable = 1'b1;
        wait_cnt(8'd0);
        check("gate_ch0", hi[0], 0);
        check("gate_ch1", hi[1], 10);
        check("gate_ch2", hi[2], 0);
        check("gate_ps", ps_n, 1);

        // Rising-edge placement with all levels at 50
        load(8'd50, 8'd50, 8'd50);
        wait_cnt(8'd0);
        measure_period(50, 50, 50);
        check("rise_ch0", rise_at[0], RISE[0]);
        check("rise_ch1", rise_at[1], RISE[1]);
        check("rise_ch2", rise_at[2], RISE[2]);

        // Reset mid-handshake discards pending and active levels
        level_in    = {8'd200, 8'd200, 8'd200};
        level_valid = 1'b1;
        step();
        level_valid = 1'b0;
        reset = 1'b1;
        step();
        check("rst2_ready", level_ready, 0);
        reset = 1'b0;
        #1;
        check("rst2_release", level_ready, 1);
        measure_period(0, 0, 0);
        measure_period(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
